// File: rtl/sm_adder_pkg.sv
// Shared types and reference arithmetic for the sign-magnitude adder slice.
// Operand/sum typedefs, result entry, FSM encoding, sm_add_ref().
package sm_adder_pkg;

  localparam int SM_DW    = 8;
  localparam int SM_MAX_W = 16;

  typedef logic [SM_DW-1:0] sm_operand_t;
  typedef logic [SM_DW:0]   sm_sum_t;

  typedef struct packed {
    sm_operand_t a;
    sm_operand_t b;
    sm_sum_t     sum;
  } sm_result_t;

  typedef enum logic [1:0] {
    SM_IDLE  = 2'd0,
    SM_ISSUE = 2'd1,
    SM_DRAIN = 2'd2,
    SM_DONE  = 2'd3
  } sm_state_e;

  typedef logic [SM_MAX_W-1:0] sm_wide_t;
  typedef logic [SM_MAX_W:0]   sm_wide_sum_t;

  // Sign-magnitude add of two w-bit operands (MSB = sign).
  // Result: bit w = sign, bits w-1:0 = magnitude; zero is never negative.
  function automatic sm_wide_sum_t sm_add_ref(
    input sm_wide_t    a,
    input sm_wide_t    b,
    input int unsigned w
  );
    sm_wide_t sbit;
    sm_wide_t mask;
    sm_wide_t ma;
    sm_wide_t mb;
    sm_wide_t mag;
    logic     sa;
    logic     sb;
    logic     s;
    sbit = sm_wide_t'(1) << (w - 1);
    mask = sbit - sm_wide_t'(1);
    ma   = a & mask;
    mb   = b & mask;
    sa   = |(a & sbit);
    sb   = |(b & sbit);
    if (sa == sb) begin
      mag = ma + mb;
      s   = sa;
    end else if (ma >= mb) begin
      mag = ma - mb;
      s   = sa;
    end else begin
      mag = mb - ma;
      s   = sb;
    end
    if (mag == '0) s = 1'b0;
    return sm_wide_sum_t'(mag) | (sm_wide_sum_t'(s) << w);
  endfunction

endpackage

// File: rtl/sm_seq_if.sv
// Operand/result bus between the sequencer, the adder ROM and the consumer.
// master = sequencer side, slave = adder + result consumer side.
interface sm_seq_if #(
  parameter int DW = 8
);

  logic [DW-1:0] a_o;
  logic [DW-1:0] b_o;
  logic [DW:0]   sum_i;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_a;
  logic [DW-1:0] res_b;
  logic [DW:0]   res_sum;

  modport master (
    output a_o,
    output b_o,
    input  sum_i,
    output res_valid,
    input  res_ready,
    output res_a,
    output res_b,
    output res_sum
  );

  modport slave (
    input  a_o,
    input  b_o,
    output sum_i,
    input  res_valid,
    output res_ready,
    input  res_a,
    input  res_b,
    input  res_sum
  );

endinterface

// File: rtl/sm_seq_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count.
// DEPTH must be a power of two and >= 2.
module sm_seq_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             pop_ok;

  assign pop_ok = pop & valid;
  assign valid  = (count != '0);
  assign full   = (count == CW'(DEPTH));
  assign dout   = mem[rp];

  // Storage write; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  // Pointer and occupancy bookkeeping; push+pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push)   wp <= wp + 1'b1;
      if (pop_ok) rp <= rp + 1'b1;
      unique case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sm_adder_operand_sequencer.sv
// Sweeps all {a,b} pairs through the SM adder ROM, realigns sums, streams results.
// Optional SM_SEQ_CHECK_EN adds a reference checker with err_flag/err_count.
module sm_adder_operand_sequencer
  import sm_adder_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
`ifdef SM_SEQ_CHECK_EN
  output logic        err_flag,
  output logic [15:0] err_count,
`endif
  sm_seq_if.master    bus
);

  localparam int PW  = 2 * DATA_WIDTH;
  localparam int SW  = DATA_WIDTH + 1;
  localparam int EW  = PW + SW;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW  = $clog2(FIFO_DEPTH + ROM_LATENCY + 1) + 1;

  localparam logic [1:0] ST_IDLE  = SM_IDLE;
  localparam logic [1:0] ST_ISSUE = SM_ISSUE;
  localparam logic [1:0] ST_DRAIN = SM_DRAIN;
  localparam logic [1:0] ST_DONE  = SM_DONE;

  logic [1:0]             state;
  logic [PW-1:0]          cnt;
  logic [ROM_LATENCY-1:0] pv;
  logic [PW-1:0]          pd [ROM_LATENCY];
  logic [PW-1:0]          ex_pair;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          outstanding;
  logic [FCW-1:0]         fcount;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   fifo_valid;
  logic                   fifo_full;
  logic [EW-1:0]          fifo_din;
  logic [EW-1:0]          fifo_dout;

  assign ex_pair  = pd[ROM_LATENCY-1];
  assign push     = pv[ROM_LATENCY-1];
  assign pop      = fifo_valid & bus.res_ready;
  assign fifo_din = {ex_pair, bus.sum_i};

  assign outstanding = inflight + CW'(fcount);
  assign issue = (state == ST_ISSUE) &&
                 (outstanding < CW'(FIFO_DEPTH));

  assign busy = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  assign bus.res_valid = fifo_valid;
  assign bus.res_a     = fifo_dout[EW-1 -: DATA_WIDTH];
  assign bus.res_b     = fifo_dout[SW +: DATA_WIDTH];
  assign bus.res_sum   = fifo_dout[SW-1:0];

  // Pairs still travelling through the adder ROM.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      inflight = inflight + CW'(pv[i]);
    end
  end

  // Sweep control: counter, issued operands and state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bus.a_o <= '0;
      bus.b_o <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ISSUE;
            cnt   <= '0;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            {bus.a_o, bus.b_o} <= cnt;
            if (&cnt) state <= ST_DRAIN;
            else      cnt   <= cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (inflight == '0 && !fifo_valid) state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Alignment pipe: follows each issued pair until its sum arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      pv <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) pd[i] <= '0;
    end else begin
      pv[0] <= issue;
      pd[0] <= cnt;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  sm_seq_result_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .full  (fifo_full),
    .count (fcount)
  );

  // Credits reserve a slot for every in-flight pair.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset) !(push && fifo_full)
  );

`ifdef SM_SEQ_CHECK_EN
  sm_wide_sum_t ref_sum;
  logic         mism;

  // Reference sum for the pair leaving the alignment pipe.
  always_comb begin
    ref_sum = sm_add_ref(
      sm_wide_t'(ex_pair[PW-1:DATA_WIDTH]),
      sm_wide_t'(ex_pair[DATA_WIDTH-1:0]),
      DATA_WIDTH);
    mism = push && (ref_sum != sm_wide_sum_t'(bus.sum_i));
  end

  // Sticky flag and saturating count; cleared by reset or a new sweep.
  always_ff @(posedge clk) begin
    if (reset || (state == ST_IDLE && start)) begin
      err_flag  <= 1'b0;
      err_count <= '0;
    end else if (mism) begin
      err_flag <= 1'b1;
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sm_adder_operand_sequencer.sv
// Scoreboard bench: DUT0 (W=4, L=1) and DUT1 (W=4, L=3) driven by ROM models.
// Optional SM_SEQ_CHECK_EN exercises the checker with a planted bad sum.
module tb_sm_adder_operand_sequencer;
  import sm_adder_pkg::*;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] s;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  logic busy0, busy1, done0, done1;
  logic inj;
  logic [4:0] r1, r2;
`ifdef SM_SEQ_CHECK_EN
  logic        ef0, ef1;
  logic [15:0] ec0, ec1;
`endif

  int tests = 0;
  int fails = 0;
  int dc0 = 0, dc1 = 0;
  int pc0 = 0, pc1 = 0;
  int base, cyc, d, issued;
  logic [7:0] frozen;
  ent_t exp0[$];
  ent_t exp1[$];

  sm_seq_if #(.DW(4)) if0 ();
  sm_seq_if #(.DW(4)) if1 ();

  always #5 clk = ~clk;

  function automatic logic [4:0] rom4(input logic [3:0] a, input logic [3:0] b);
    sm_wide_sum_t r;
    r = sm_add_ref(sm_wide_t'(a), sm_wide_t'(b), 4);
    return 5'(r);
  endfunction

  sm_adder_operand_sequencer #(
    .DATA_WIDTH(4), .ROM_LATENCY(1), .FIFO_DEPTH(4)
  ) u0 (
    .clk(clk), .reset(rst), .start(start0),
    .busy(busy0), .done(done0),
`ifdef SM_SEQ_CHECK_EN
    .err_flag(ef0), .err_count(ec0),
`endif
    .bus(if0)
  );

  sm_adder_operand_sequencer #(
    .DATA_WIDTH(4), .ROM_LATENCY(3), .FIFO_DEPTH(4)
  ) u1 (
    .clk(clk), .reset(rst), .start(start1),
    .busy(busy1), .done(done1),
`ifdef SM_SEQ_CHECK_EN
    .err_flag(ef1), .err_count(ec1),
`endif
    .bus(if1)
  );

  // ROM for DUT0: combinational read, optional corruption of pair (3,5).
  assign if0.sum_i = rom4(if0.a_o, if0.b_o) ^
    {4'b0, inj && if0.a_o == 4'd3 && if0.b_o == 4'd5};

  // ROM for DUT1: two register stages after the read.
  always @(posedge clk) begin
    r1 <= rom4(if1.a_o, if1.b_o);
    r2 <= r1;
  end
  assign if1.sum_i = r2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int who, input logic bad);
    ent_t e;
    for (int i = 0; i < 256; i++) begin
      e.a = 4'(i >> 4);
      e.b = 4'(i);
      e.s = rom4(e.a, e.b);
      if (bad && e.a == 4'd3 && e.b == 4'd5) e.s = e.s ^ 5'd1;
      if (who == 0) exp0.push_back(e);
      else          exp1.push_back(e);
    end
  endtask

  task automatic kick(input int who);
    @(posedge clk); #1;
    if (who == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int who, input logic rnd, output int n);
    int d0;
    d0 = (who == 0) ? dc0 : dc1;
    n = 0;
    while (((who == 0) ? dc0 : dc1) == d0 && n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (rnd) if1.res_ready = 1'($urandom_range(0, 1));
    end
    chk("done_seen", 32'((who == 0) ? dc0 : dc1), 32'(d0 + 1));
  endtask

  // DUT0 scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (!rst && if0.res_valid && if0.res_ready) begin
      pc0++;
      if (exp0.size() == 0) chk("d0_extra", 32'd1, 32'd0);
      else chk("d0_res", 32'({if0.res_a, if0.res_b, if0.res_sum}),
               32'(exp0.pop_front()));
    end
    if (!rst && done0) dc0++;
  end

  // DUT1 scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (!rst && if1.res_valid && if1.res_ready) begin
      pc1++;
      if (exp1.size() == 0) chk("d1_extra", 32'd1, 32'd0);
      else chk("d1_res", 32'({if1.res_a, if1.res_b, if1.res_sum}),
               32'(exp1.pop_front()));
    end
    if (!rst && done1) dc1++;
  end

  initial begin
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    inj = 1'b0;
    if0.res_ready = 1'b1;
    if1.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(if0.res_valid), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_ab", 32'({if0.a_o, if0.b_o}), 32'd0);
    chk("rst_valid1", 32'(if1.res_valid), 32'd0);
    rst = 1'b0;

    // Reference arithmetic at W=8 and W=4.
    chk("ref_1p2", 32'(sm_add_ref(16'h01, 16'h02, 8)), 32'h003);
    chk("ref_m5p3", 32'(sm_add_ref(16'h85, 16'h03, 8)), 32'h102);
    chk("ref_negzero", 32'(sm_add_ref(16'h83, 16'h03, 8)), 32'h000);
    chk("ref4_m7m7", 32'(rom4(4'hF, 4'hF)), 32'h1E);
    chk("ref4_2m3", 32'(rom4(4'h2, 4'hB)), 32'h11);
    chk("ref4_3p5", 32'(rom4(4'h3, 4'h5)), 32'h08);

    // Full sweep, consumer always ready.
    load(0, 1'b0);
    base = pc0;
    d = dc0;
    kick(0);
    chk("t1_busy", 32'(busy0), 32'd1);
    wait_done(0, 1'b0, cyc);
    chk("t1_rate", 32'(cyc <= 270), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("t1_pops", 32'(pc0 - base), 32'd256);
    chk("t1_empty", 32'(exp0.size()), 32'd0);
    chk("t1_one_done", 32'(dc0), 32'(d + 1));
    chk("t1_idle", 32'(busy0), 32'd0);
`ifdef SM_SEQ_CHECK_EN
    chk("t1_errflag", 32'(ef0), 32'd0);
    chk("t1_errcnt", 32'(ec0), 32'd0);
`endif

    // Stall the consumer mid-sweep.
    load(0, 1'b0);
    base = pc0;
    kick(0);
    repeat (40) @(posedge clk);
    #1;
    if0.res_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    frozen = {if0.a_o, if0.b_o};
    repeat (10) @(posedge clk);
    #1;
    chk("t2_frozen", 32'({if0.a_o, if0.b_o}), 32'(frozen));
    issued = int'({if0.a_o, if0.b_o}) + 1;
    chk("t2_outstanding", 32'(issued - (pc0 - base)), 32'd4);
    chk("t2_valid", 32'(if0.res_valid), 32'd1);
    if0.res_ready = 1'b1;
    wait_done(0, 1'b0, cyc);
    chk("t2_pops", 32'(pc0 - base), 32'd256);
    chk("t2_empty", 32'(exp0.size()), 32'd0);

    // Reset mid-sweep, then a clean restart.
    load(0, 1'b0);
    kick(0);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp0.delete();
    chk("t5_valid", 32'(if0.res_valid), 32'd0);
    chk("t5_busy", 32'(busy0), 32'd0);
    chk("t5_ab", 32'({if0.a_o, if0.b_o}), 32'd0);
    rst = 1'b0;
    load(0, 1'b0);
    base = pc0;
    kick(0);
    wait_done(0, 1'b0, cyc);
    chk("t5_pops", 32'(pc0 - base), 32'd256);
    chk("t5_empty", 32'(exp0.size()), 32'd0);

    // Three-cycle ROM with a randomly stalling consumer.
    load(1, 1'b0);
    base = pc1;
    kick(1);
    chk("t4_busy", 32'(busy1), 32'd1);
    wait_done(1, 1'b1, cyc);
    if1.res_ready = 1'b1;
    chk("t4_pops", 32'(pc1 - base), 32'd256);
    chk("t4_empty", 32'(exp1.size()), 32'd0);

`ifdef SM_SEQ_CHECK_EN
    // Corrupt the sum of pair (3,5) once.
    load(0, 1'b1);
    inj = 1'b1;
    kick(0);
    wait_done(0, 1'b0, cyc);
    inj = 1'b0;
    chk("t6_flag", 32'(ef0), 32'd1);
    chk("t6_count", 32'(ec0), 32'd1);
    chk("t6_d1_clean", 32'(ec1), 32'd0);
    load(0, 1'b0);
    kick(0);
    chk("t6_cleared", 32'(ef0), 32'd0);
    wait_done(0, 1'b0, cyc);
    chk("t6_clean", 32'(ec0), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
